player_link_rx: RTL and testbench

- Receive side of the two-board player link.
- The opponent board drives 6 level signals on its player-1 header: pause, reload, score[3:0]. This block takes those raw, asynchronous, possibly skewed and bouncing pins and produces clean, validated player-2 state plus single-cycle event strobes.
- It sits in the game-logic clock domain (65 MHz) between the JC header pins and the game FSM / score display.

---
 rtl/player_link_rx.sv | 134 +++++++++++++
 tb/tb_player_link_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_link_rx.sv
// player_link_rx
//   Receive side of the two-board player link. The opponent board drives six
//   level pins (pause, reload, score[3:0]) that arrive asynchronous, skewed
//   and possibly bouncing. Each pin is synchronized, then the whole 6-bit word
//   must hold steady for STABLE_CYCLES clocks before it is accepted as the
//   clean player-2 state. Event strobes are derived from the old and new
//   accepted words and are registered alongside them.
//
// Ports
//   clk                 system clock (game-logic domain)
//   rst_n               asynchronous, active-low reset
//   player2_pause_raw   raw pause pin from opponent
//   player2_reload_raw  raw reload pin from opponent
//   player2_score_raw   raw 4-bit score pins from opponent
//   player2_pause       accepted pause level
//   player2_reload      accepted reload level
//   player2_score       accepted score
//   pause_rise          1-cycle strobe, accepted pause 0->1
//   pause_fall          1-cycle strobe, accepted pause 1->0
//   reload_pulse        1-cycle strobe, accepted reload 0->1
//   score_update        1-cycle strobe, accepted score changed
//   score_error         1-cycle strobe, score change was not +1 (mod 16) or ->0
module player_link_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 65000,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       player2_pause_raw,
  input  logic       player2_reload_raw,
  input  logic [3:0] player2_score_raw,
  output logic       player2_pause,
  output logic       player2_reload,
  output logic [3:0] player2_score,
  output logic       pause_rise,
  output logic       pause_fall,
  output logic       reload_pulse,
  output logic       score_update,
  output logic       score_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Word layout everywhere: {reload, pause, score[3:0]}
  logic [5:0]       w_raw;
  logic [5:0]       w_sync;
  logic [5:0]       r_sync [SYNC_STAGES];
  logic [5:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_acc;
  logic             r_pause_rise;
  logic             r_pause_fall;
  logic             r_reload_pulse;
  logic             r_score_update;
  logic             r_score_error;

  logic             w_accept;
  logic [3:0]       w_score_next;
  logic             w_score_chg;
  logic             w_score_err;

  assign w_raw  = {player2_reload_raw, player2_pause_raw, player2_score_raw};
  assign w_sync = r_sync[SYNC_STAGES-1];

  // Plain multi-flop synchronizer per bit; no cross-bit logic before the
  // filter so skew between pins is absorbed by the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Stability filter: any change in the synchronized word restarts the
  // count; the counter saturates so a steady word keeps being re-accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (w_sync != r_cand) begin
      r_cand <= w_sync;
      r_cnt  <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign w_accept     = (w_sync == r_cand) && (r_cnt == CNT_MAX);
  assign w_score_next = r_acc[3:0] + 4'd1;
  assign w_score_chg  = r_cand[3:0] != r_acc[3:0];
  // Only +1 (wrapping 15->0) or a drop to 0 (opponent reset) are legal.
  assign w_score_err  = w_score_chg && (r_cand[3:0] != w_score_next) &&
                        (r_cand[3:0] != 4'd0);

  // Accepted word and strobes update together, so strobes line up with the
  // first cycle the new value is visible. Re-accepting an unchanged word
  // yields all-zero strobes naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc          <= '0;
      r_pause_rise   <= 1'b0;
      r_pause_fall   <= 1'b0;
      r_reload_pulse <= 1'b0;
      r_score_update <= 1'b0;
      r_score_error  <= 1'b0;
    end else if (w_accept) begin
      r_acc          <= r_cand;
      r_pause_rise   <= !r_acc[4] &&  r_cand[4];
      r_pause_fall   <=  r_acc[4] && !r_cand[4];
      r_reload_pulse <= !r_acc[5] &&  r_cand[5];
      r_score_update <= w_score_chg;
      r_score_error  <= w_score_err;
    end else begin
      r_pause_rise   <= 1'b0;
      r_pause_fall   <= 1'b0;
      r_reload_pulse <= 1'b0;
      r_score_update <= 1'b0;
      r_score_error  <= 1'b0;
    end
  end

  assign player2_reload = r_acc[5];
  assign player2_pause  = r_acc[4];
  assign player2_score  = r_acc[3:0];
  assign pause_rise     = r_pause_rise;
  assign pause_fall     = r_pause_fall;
  assign reload_pulse   = r_reload_pulse;
  assign score_update   = r_score_update;
  assign score_error    = r_score_error;

endmodule

// File: tb/tb_player_link_rx.sv
// tb_player_link_rx
//   Drives player_link_rx (SYNC_STAGES=2, STABLE_CYCLES=8) with directed and
//   random raw pin patterns. A reference model tracks the raw words the DUT
//   will see and decides acceptance from a sliding window of identical
//   samples; every accepted change pushes the expected levels, strobes and
//   edge number into a queue that a separate monitor pops whenever the DUT
//   presents an event.
module tb_player_link_rx;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;

  typedef struct {
    int         edgeNo;
    logic [5:0] word;
    logic [4:0] strobes;
  } expT;

  logic       clk;
  logic       rst_n;
  logic       pauseRaw;
  logic       reloadRaw;
  logic [3:0] scoreRaw;
  logic       p2Pause;
  logic       p2Reload;
  logic [3:0] p2Score;
  logic       pauseRise;
  logic       pauseFall;
  logic       reloadPulse;
  logic       scoreUpdate;
  logic       scoreError;

  int totalChecks = 0;
  int badChecks   = 0;
  int edgeCnt     = 0;

  expT        sbQ[$];
  logic [5:0] rawQ[$];
  logic [5:0] win[$];
  logic [5:0] modelAcc = '0;
  logic [5:0] prevLevels = '0;

  player_link_rx #(
    .SYNC_STAGES(SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .player2_pause_raw(pauseRaw),
    .player2_reload_raw(reloadRaw),
    .player2_score_raw(scoreRaw),
    .player2_pause(p2Pause),
    .player2_reload(p2Reload),
    .player2_score(p2Score),
    .pause_rise(pauseRise),
    .pause_fall(pauseFall),
    .reload_pulse(reloadPulse),
    .score_update(scoreUpdate),
    .score_error(scoreError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records one comparison and reports it on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)",
               name, actual, expected, edgeCnt);
    end
  endtask

  // Holds a raw word {reload, pause, score} on the pins for some cycles.
  task automatic applyStimulus(input logic [5:0] word, input int cycles);
    @(negedge clk);
    reloadRaw = word[5];
    pauseRaw  = word[4];
    scoreRaw  = word[3:0];
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: the filter sees each raw word SYNC edges later; a word
  // is accepted once it has been seen on STABLE+1 consecutive edges (reset
  // itself counts as one sighting of 0). Strobes follow from old/new words.
  always @(posedge clk) begin
    logic [5:0] s;
    logic       same;
    expT        e;
    int         oldS;
    int         newS;
    edgeCnt++;
    if (!rst_n) begin
      rawQ.delete();
      for (int i = 0; i < SYNC; i++) rawQ.push_back(6'd0);
      win.delete();
      win.push_back(6'd0);
      modelAcc = '0;
    end else begin
      rawQ.push_back({reloadRaw, pauseRaw, scoreRaw});
      s = rawQ.pop_front();
      win.push_back(s);
      if (win.size() > STABLE + 1) void'(win.pop_front());
      same = 1'b1;
      foreach (win[i]) if (win[i] != s) same = 1'b0;
      if (win.size() == STABLE + 1 && same && s != modelAcc) begin
        oldS = int'(modelAcc[3:0]);
        newS = int'(s[3:0]);
        e.edgeNo     = edgeCnt;
        e.word       = s;
        e.strobes[4] = !modelAcc[4] && s[4];
        e.strobes[3] = modelAcc[4] && !s[4];
        e.strobes[2] = !modelAcc[5] && s[5];
        e.strobes[1] = oldS != newS;
        e.strobes[0] = (oldS != newS) && (newS != (oldS + 1) % 16) && (newS != 0);
        sbQ.push_back(e);
        modelAcc = s;
      end
    end
  end

  // Monitor: samples just after each rising edge, checks the held levels
  // every cycle and matches each presented event against the queue head.
  always @(posedge clk) begin
    logic [5:0] lv;
    logic [4:0] st;
    expT        e;
    #1;
    lv = {p2Reload, p2Pause, p2Score};
    st = {pauseRise, pauseFall, reloadPulse, scoreUpdate, scoreError};
    if (!rst_n) begin
      checkOutput("resetOutputs", {21'd0, lv, st}, 32'd0);
      prevLevels = '0;
    end else begin
      checkOutput("levels", {26'd0, lv}, {26'd0, modelAcc});
      if (st != 5'd0 || lv != prevLevels) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedEvent", {21'd0, lv, st}, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("eventEdge", edgeCnt, e.edgeNo);
          checkOutput("eventWord", {26'd0, lv}, {26'd0, e.word});
          checkOutput("eventStrobes", {27'd0, st}, {27'd0, e.strobes});
        end
      end else if (sbQ.size() > 0 && sbQ[0].edgeNo <= edgeCnt) begin
        e = sbQ.pop_front();
        checkOutput("missedEvent", {26'd0, lv}, {26'd0, e.word});
      end
      prevLevels = lv;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] w;
    int         sc;
    rst_n     = 1'b0;
    pauseRaw  = 1'b0;
    reloadRaw = 1'b0;
    scoreRaw  = 4'd0;
    applyReset(3);
    $display("[TB] idle after reset");
    applyStimulus(6'h00, 50);

    $display("[TB] score 0->1");
    applyStimulus(6'h01, 20);

    $display("[TB] pause glitch, then held and released");
    applyStimulus(6'h11, 5);
    applyStimulus(6'h01, 20);
    applyStimulus(6'h11, 20);
    applyStimulus(6'h01, 20);

    $display("[TB] skewed 3->4");
    applyStimulus(6'h03, 20);
    applyStimulus(6'h00, 3);
    applyStimulus(6'h04, 20);

    $display("[TB] illegal step, drop to 0, wrap, reload with score");
    applyStimulus(6'h02, 20);
    applyStimulus(6'h05, 20);
    applyStimulus(6'h00, 20);
    applyStimulus(6'h0F, 20);
    applyStimulus(6'h00, 20);
    applyStimulus(6'h06, 20);
    applyStimulus(6'h27, 20);
    applyStimulus(6'h07, 20);

    $display("[TB] reset mid-filter");
    applyStimulus(6'h03, 7);
    @(negedge clk);
    scoreRaw = 4'd9;
    applyReset(4);
    applyStimulus(6'h09, 20);

    $display("[TB] random phase");
    sc = 9;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       sc = (sc + 1) % 16;
        1:       sc = 0;
        default: sc = int'($urandom_range(0, 15));
      endcase
      w = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'(sc)};
      applyStimulus(w, int'($urandom_range(1, 16)));
    end
    applyStimulus(6'h00, 20);

    checkOutput("queueDrained", sbQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
